// File: rtl/rv32_pipeline_core.sv
// rv32_pipeline_core: three-stage (IF / EX / WB) RV32I + Zicsr core with an internal 64 KiB byte memory.
// Define CORE_TRAP_EN to make ECALL/MRET trap and return; without it both execute as NOPs.

module rv32_pipeline_core_mem (
    input  logic        clk_i,
    input  logic [15:0] iaddr_i,
    output logic [31:0] idata_o,
    input  logic [15:0] daddr_i,
    output logic [31:0] drdata_o,
    input  logic [3:0]  dwe_i,
    input  logic [31:0] dwdata_i
);
    logic [7:0] m [0:65535];

    // Each byte lane wraps independently, so misaligned words straddle 0xFFFF -> 0x0000.
    logic [15:0] ia1, ia2, ia3, da1, da2, da3;

    assign ia1 = iaddr_i + 16'd1;
    assign ia2 = iaddr_i + 16'd2;
    assign ia3 = iaddr_i + 16'd3;
    assign da1 = daddr_i + 16'd1;
    assign da2 = daddr_i + 16'd2;
    assign da3 = daddr_i + 16'd3;

    assign idata_o  = {m[ia3], m[ia2], m[ia1], m[iaddr_i]};
    assign drdata_o = {m[da3], m[da2], m[da1], m[daddr_i]};

    always_ff @(posedge clk_i) begin
        if (dwe_i[0]) m[daddr_i] <= dwdata_i[7:0];
        if (dwe_i[1]) m[da1]     <= dwdata_i[15:8];
        if (dwe_i[2]) m[da2]     <= dwdata_i[23:16];
        if (dwe_i[3]) m[da3]     <= dwdata_i[31:24];
    end
endmodule

module rv32_pipeline_core (
    input  logic clk,
    input  logic rst
);
    typedef enum logic [6:0] {
        OPC_LUI     = 7'b0110111,
        OPC_AUIPC   = 7'b0010111,
        OPC_JAL     = 7'b1101111,
        OPC_JALR    = 7'b1100111,
        OPC_BRANCH  = 7'b1100011,
        OPC_LOAD    = 7'b0000011,
        OPC_STORE   = 7'b0100011,
        OPC_OPIMM   = 7'b0010011,
        OPC_OP      = 7'b0110011,
        OPC_MISCMEM = 7'b0001111,
        OPC_SYSTEM  = 7'b1110011
    } opcode_e;

    logic [31:0] if_pc;
    logic [31:0] if_pc_d;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic        ifex_valid_q;
    logic [31:0] ifex_instr_q;
    logic [31:0] ifex_pc_q;
    logic        exwb_we_q;
    logic [4:0]  exwb_rd_q;
    logic [31:0] exwb_data_q;

    logic [31:0] imem_rdata, dmem_rdata, dmem_wdata;
    logic [15:0] dmem_addr;
    logic [3:0]  dmem_we;

    rv32_pipeline_core_mem memory (
        .clk_i    (clk),
        .iaddr_i  (if_pc[15:0]),
        .idata_o  (imem_rdata),
        .daddr_i  (dmem_addr),
        .drdata_o (dmem_rdata),
        .dwe_i    (dmem_we),
        .dwdata_i (dmem_wdata)
    );

    opcode_e     opc;
    logic [4:0]  rd, rs1a, rs2a;
    logic [2:0]  f3;
    logic [11:0] csr_addr;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic [15:0] imm_s16;

    assign opc      = opcode_e'(ifex_instr_q[6:0]);
    assign rd       = ifex_instr_q[11:7];
    assign f3       = ifex_instr_q[14:12];
    assign rs1a     = ifex_instr_q[19:15];
    assign rs2a     = ifex_instr_q[24:20];
    assign csr_addr = ifex_instr_q[31:20];
    assign imm_i    = {{20{ifex_instr_q[31]}}, ifex_instr_q[31:20]};
    assign imm_s16  = {{4{ifex_instr_q[31]}}, ifex_instr_q[31:25], ifex_instr_q[11:7]};
    assign imm_b    = {{19{ifex_instr_q[31]}}, ifex_instr_q[31], ifex_instr_q[7],
                       ifex_instr_q[30:25], ifex_instr_q[11:8], 1'b0};
    assign imm_u    = {ifex_instr_q[31:12], 12'b0};
    assign imm_j    = {{11{ifex_instr_q[31]}}, ifex_instr_q[31], ifex_instr_q[19:12],
                       ifex_instr_q[20], ifex_instr_q[30:21], 1'b0};

    // The instruction in WB has not reached the register file yet, so forward it.
    logic [31:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1a != 5'd0)
            rs1_val = (exwb_we_q && exwb_rd_q == rs1a) ? exwb_data_q : rs[rs1a];
        if (rs2a != 5'd0)
            rs2_val = (exwb_we_q && exwb_rd_q == rs2a) ? exwb_data_q : rs[rs2a];
    end

    logic [31:0] alu_b, alu_res;
    logic        alu_alt;
    logic [4:0]  shamt;

    assign alu_b   = (opc == OPC_OP) ? rs2_val : imm_i;
    assign alu_alt = ifex_instr_q[30] && ((opc == OPC_OP) || (f3 == 3'b101));
    assign shamt   = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = alu_alt ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    logic [31:0] load_val;

    always_comb begin
        case (f3)
            3'b000:  load_val = {{24{dmem_rdata[7]}}, dmem_rdata[7:0]};
            3'b001:  load_val = {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
            3'b100:  load_val = {24'b0, dmem_rdata[7:0]};
            3'b101:  load_val = {16'b0, dmem_rdata[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    assign dmem_addr  = rs1_val[15:0] + ((opc == OPC_STORE) ? imm_s16 : imm_i[15:0]);
    assign dmem_wdata = rs2_val;

    logic        wb_en, redirect, csr_we;
    logic [31:0] wb_data, target, csr_wdata, csr_old, csr_src;
`ifdef CORE_TRAP_EN
    logic        trap_we;
`endif

    assign csr_old = csr[csr_addr];
    assign csr_src = f3[2] ? {27'b0, rs1a} : rs1_val;

    always_comb begin
        wb_en     = 1'b0;
        wb_data   = alu_res;
        redirect  = 1'b0;
        target    = ifex_pc_q + imm_b;
        dmem_we   = '0;
        csr_we    = 1'b0;
        csr_wdata = '0;
`ifdef CORE_TRAP_EN
        trap_we   = 1'b0;
`endif
        if (ifex_valid_q) begin
            case (opc)
                OPC_LUI: begin
                    wb_en   = 1'b1;
                    wb_data = imm_u;
                end
                OPC_AUIPC: begin
                    wb_en   = 1'b1;
                    wb_data = ifex_pc_q + imm_u;
                end
                OPC_JAL: begin
                    wb_en    = 1'b1;
                    wb_data  = ifex_pc_q + 32'd4;
                    redirect = 1'b1;
                    target   = ifex_pc_q + imm_j;
                end
                OPC_JALR: begin
                    wb_en    = 1'b1;
                    wb_data  = ifex_pc_q + 32'd4;
                    redirect = 1'b1;
                    target   = (rs1_val + imm_i) & ~32'd1;
                end
                OPC_BRANCH: redirect = br_taken;
                OPC_LOAD: begin
                    wb_en   = 1'b1;
                    wb_data = load_val;
                end
                OPC_STORE: begin
                    case (f3)
                        3'b000:  dmem_we = 4'b0001;
                        3'b001:  dmem_we = 4'b0011;
                        3'b010:  dmem_we = 4'b1111;
                        default: dmem_we = 4'b0000;
                    endcase
                end
                OPC_OPIMM, OPC_OP: wb_en = 1'b1;
                OPC_SYSTEM: begin
                    if (f3[1:0] != 2'b00) begin
                        wb_en   = 1'b1;
                        wb_data = csr_old;
                        case (f3[1:0])
                            2'b01: begin
                                csr_we    = 1'b1;
                                csr_wdata = csr_src;
                            end
                            2'b10: begin
                                csr_we    = (rs1a != 5'd0);
                                csr_wdata = csr_old | csr_src;
                            end
                            default: begin
                                csr_we    = (rs1a != 5'd0);
                                csr_wdata = csr_old & ~csr_src;
                            end
                        endcase
                    end
`ifdef CORE_TRAP_EN
                    else if (f3 == 3'b000 && csr_addr == 12'h000) begin
                        redirect = 1'b1;
                        target   = {csr[12'h305][31:2], 2'b00};
                        trap_we  = 1'b1;
                    end else if (f3 == 3'b000 && csr_addr == 12'h302) begin
                        redirect = 1'b1;
                        target   = csr[12'h341];
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign if_pc_d = redirect ? target : if_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc        <= '0;
            ifex_valid_q <= 1'b0;
            exwb_we_q    <= 1'b0;
        end else begin
            if_pc        <= if_pc_d;
            ifex_valid_q <= ~redirect;
            exwb_we_q    <= wb_en && (rd != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        ifex_instr_q <= imem_rdata;
        ifex_pc_q    <= if_pc;
        exwb_rd_q    <= rd;
        exwb_data_q  <= wb_data;
    end

    for (genvar g = 0; g < 32; g++) begin : g_rf
        always_ff @(posedge clk) begin
            if (rst)
                rs[g] <= '0;
            else if (exwb_we_q && exwb_rd_q == 5'(g))
                rs[g] <= exwb_data_q;
        end
    end

    for (genvar g = 0; g < 4096; g++) begin : g_csr
        always_ff @(posedge clk) begin
            if (rst) begin
                csr[g] <= '0;
            end else begin
                if (csr_we && csr_addr == 12'(g))
                    csr[g] <= csr_wdata;
`ifdef CORE_TRAP_EN
                if (trap_we && g == 12'h341)
                    csr[g] <= ifex_pc_q;
                if (trap_we && g == 12'h342)
                    csr[g] <= 32'd11;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rv32_pipeline_core.sv
// Directed bench for rv32_pipeline_core: small hand-assembled programs with hand-computed results.
// Trap-path expectations follow CORE_TRAP_EN.

module tb_rv32_pipeline_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    rv32_pipeline_core dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] r1,
                                         input logic [11:0] imm);
        return {imm, r1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic place(input logic [15:0] a, input logic [31:0] w);
        dut.memory.m[a]         = w[7:0];
        dut.memory.m[a + 16'd1] = w[15:8];
        dut.memory.m[a + 16'd2] = w[23:16];
        dut.memory.m[a + 16'd3] = w[31:24];
    endtask

    // Hold reset across an edge so the pipeline is idle, then wipe the low program area.
    task automatic begin_prog();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 512; i++) dut.memory.m[i] = 8'h00;
    endtask

    task automatic settle_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    initial begin
        // Program A: gp=1 then a self-jump at 4.
        begin_prog();
        place(16'h0000, addi(5'd3, 5'd0, 12'd1));
        place(16'h0004, j_t(21'd0, 5'd0));
        settle_reset();
        check("A_reset_pc", dut.if_pc, 32'h0);
        check("A_reset_x3", dut.rs[3], 32'h0);
        rst = 1'b0;
        run(1); check("A_pc_e1", dut.if_pc, 32'h4);
        run(1); check("A_pc_e2", dut.if_pc, 32'h8);
                check("A_x3_e2", dut.rs[3], 32'h0);
        run(1); check("A_x3_e3", dut.rs[3], 32'h1);
                check("A_pc_e3", dut.if_pc, 32'h4);
        run(1); check("A_pc_e4", dut.if_pc, 32'h8);
        run(1); check("A_pc_e5", dut.if_pc, 32'h4);

        // Program B: compares, shifts, LUI, SUB, back-to-back bypass.
        begin_prog();
        place(16'h0000, addi(5'd1, 5'd0, 12'hFFF));
        place(16'h0004, r_t(7'd0, 5'd1, 5'd0, 3'b011, 5'd2));
        place(16'h0008, r_t(7'd0, 5'd1, 5'd0, 3'b010, 5'd4));
        place(16'h000C, r_t(7'd0, 5'd0, 5'd1, 3'b010, 5'd7));
        place(16'h0010, i_t(12'd28, 5'd1, 3'b101, 5'd11, OP_IMM));
        place(16'h0014, r_t(7'd0, 5'd11, 5'd11, 3'b001, 5'd12));
        place(16'h0018, i_t(12'h404, 5'd1, 3'b101, 5'd10, OP_IMM));
        place(16'h001C, {20'h12345, 5'd13, OP_LUI});
        place(16'h0020, r_t(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd14));
        place(16'h0024, j_t(21'd0, 5'd0));
        settle_reset();
        check("B_reset_x3", dut.rs[3], 32'h0);
        check("B_reset_pc", dut.if_pc, 32'h0);
        rst = 1'b0;
        run(16);
        check("B_x1_addi",  dut.rs[1],  32'hFFFF_FFFF);
        check("B_x2_sltu",  dut.rs[2],  32'h1);
        check("B_x4_slt",   dut.rs[4],  32'h0);
        check("B_x7_slt",   dut.rs[7],  32'h1);
        check("B_x11_srli", dut.rs[11], 32'h0000_000F);
        check("B_x12_sll",  dut.rs[12], 32'h0007_8000);
        check("B_x10_srai", dut.rs[10], 32'hFFFF_FFFF);
        check("B_x13_lui",  dut.rs[13], 32'h1234_5000);
        check("B_x14_sub",  dut.rs[14], 32'h1);

        // Program C: stores, sized loads, misaligned and wrapping accesses.
        begin_prog();
        dut.memory.m[16'hFFFE] = 8'hAA;
        dut.memory.m[16'hFFFF] = 8'hBB;
        place(16'h0000, {20'h11223, 5'd1, OP_LUI});
        place(16'h0004, addi(5'd1, 5'd1, 12'h344));
        place(16'h0008, addi(5'd2, 5'd0, 12'h100));
        place(16'h000C, s_t(12'd0, 5'd1, 5'd2, 3'b010));
        place(16'h0010, i_t(12'd1, 5'd2, 3'b000, 5'd5, OP_LOAD));
        place(16'h0014, i_t(12'd2, 5'd2, 3'b101, 5'd6, OP_LOAD));
        place(16'h0018, addi(5'd3, 5'd0, 12'hF80));
        place(16'h001C, s_t(12'h104, 5'd3, 5'd0, 3'b000));
        place(16'h0020, i_t(12'h104, 5'd0, 3'b000, 5'd15, OP_LOAD));
        place(16'h0024, i_t(12'h104, 5'd0, 3'b100, 5'd16, OP_LOAD));
        place(16'h0028, i_t(12'h101, 5'd0, 3'b010, 5'd17, OP_LOAD));
        place(16'h002C, i_t(12'hFFE, 5'd0, 3'b010, 5'd18, OP_LOAD));
        place(16'h0030, j_t(21'd0, 5'd0));
        settle_reset();
        rst = 1'b0;
        run(18);
        check("C_mem_100",  {24'b0, dut.memory.m[16'h0100]}, 32'h44);
        check("C_x5_lb",    dut.rs[5],  32'h0000_0033);
        check("C_x6_lhu",   dut.rs[6],  32'h0000_1122);
        check("C_x15_lb",   dut.rs[15], 32'hFFFF_FF80);
        check("C_x16_lbu",  dut.rs[16], 32'h0000_0080);
        check("C_x17_lwma", dut.rs[17], 32'h8011_2233);
        check("C_x18_wrap", dut.rs[18], 32'h30B7_BBAA);

        // Program D: branches, jumps, squash, x0 discard.
        begin_prog();
        place(16'h0000, addi(5'd1, 5'd0, 12'd5));
        place(16'h0004, b_t(13'd8, 5'd0, 5'd0, 3'b000));
        place(16'h0008, addi(5'd2, 5'd0, 12'd7));
        place(16'h000C, addi(5'd4, 5'd0, 12'd9));
        place(16'h0010, b_t(13'd8, 5'd0, 5'd0, 3'b001));
        place(16'h0014, addi(5'd5, 5'd0, 12'd3));
        place(16'h0018, j_t(21'd8, 5'd6));
        place(16'h001C, addi(5'd7, 5'd0, 12'd1));
        place(16'h0020, i_t(12'h030, 5'd0, 3'b000, 5'd8, OP_JALR));
        place(16'h0024, addi(5'd9, 5'd0, 12'd1));
        place(16'h0030, addi(5'd10, 5'd0, 12'hFFF));
        place(16'h0034, b_t(13'd8, 5'd0, 5'd10, 3'b100));
        place(16'h0038, addi(5'd11, 5'd0, 12'd1));
        place(16'h003C, b_t(13'd8, 5'd0, 5'd10, 3'b110));
        place(16'h0040, addi(5'd12, 5'd0, 12'd2));
        place(16'h0044, addi(5'd0, 5'd0, 12'd5));
        place(16'h0048, j_t(21'd0, 5'd0));
        settle_reset();
        rst = 1'b0;
        run(2); check("D_pc_seq",   dut.if_pc, 32'h8);
        run(1); check("D_pc_taken", dut.if_pc, 32'hC);
        run(37);
        check("D_x1",        dut.rs[1],  32'd5);
        check("D_x2_squash", dut.rs[2],  32'd0);
        check("D_x4",        dut.rs[4],  32'd9);
        check("D_x5_bne_nt", dut.rs[5],  32'd3);
        check("D_x6_jal",    dut.rs[6],  32'h1C);
        check("D_x7_squash", dut.rs[7],  32'd0);
        check("D_x8_jalr",   dut.rs[8],  32'h24);
        check("D_x9_squash", dut.rs[9],  32'd0);
        check("D_x11_blt",   dut.rs[11], 32'd0);
        check("D_x12_bltu",  dut.rs[12], 32'd2);
        check("D_x0",        dut.rs[0],  32'd0);

        // Program E: CSR read/modify, then ECALL/MRET.
        begin_prog();
        place(16'h0000, addi(5'd1, 5'd0, 12'h040));
        place(16'h0004, i_t(12'h305, 5'd1, 3'b001, 5'd0, OP_SYS));
        place(16'h0008, i_t(12'h305, 5'd0, 3'b010, 5'd2, OP_SYS));
        place(16'h000C, addi(5'd3, 5'd0, 12'd5));
        place(16'h0010, i_t(12'h340, 5'd3, 3'b001, 5'd4, OP_SYS));
        place(16'h0014, i_t(12'h340, 5'd1, 3'b111, 5'd5, OP_SYS));
        place(16'h0018, i_t(12'h340, 5'h10, 3'b110, 5'd6, OP_SYS));
        place(16'h001C, i_t(12'h340, 5'd0, 3'b010, 5'd9, OP_SYS));
        place(16'h0020, 32'h0000_0073);
        place(16'h0024, addi(5'd7, 5'd0, 12'd1));
        place(16'h0028, j_t(21'd0, 5'd0));
        place(16'h0040, 32'h3020_0073);
        place(16'h0044, j_t(21'd0, 5'd0));
        settle_reset();
        rst = 1'b0;
        run(10);
`ifdef CORE_TRAP_EN
        check("E_pc_trap", dut.if_pc,        32'h40);
        check("E_mepc",    dut.csr[12'h341], 32'h20);
        check("E_mcause",  dut.csr[12'h342], 32'd11);
        run(2);
        check("E_pc_mret", dut.if_pc,        32'h20);
        check("E_x7",      dut.rs[7],        32'd0);
`else
        check("E_pc_seq",  dut.if_pc,        32'h28);
        check("E_mepc",    dut.csr[12'h341], 32'h0);
        check("E_mcause",  dut.csr[12'h342], 32'h0);
        run(2);
        check("E_pc_loop", dut.if_pc,        32'h28);
        check("E_x7",      dut.rs[7],        32'd1);
`endif
        check("E_mtvec",   dut.csr[12'h305], 32'h40);
        check("E_mscratch",dut.csr[12'h340], 32'h14);
        check("E_x2_csrr", dut.rs[2],        32'h40);
        check("E_x4_csrrw",dut.rs[4],        32'h0);
        check("E_x5_csrrc",dut.rs[5],        32'h5);
        check("E_x6_csrrs",dut.rs[6],        32'h4);
        check("E_x9_csrr", dut.rs[9],        32'h14);

        // Final reset clears CSRs and registers.
        begin_prog();
        settle_reset();
        check("F_reset_csr", dut.csr[12'h340], 32'h0);
        check("F_reset_x6",  dut.rs[6],        32'h0);
        check("F_reset_pc",  dut.if_pc,        32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
